line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl_if.sv | 33 +++
 rtl/line_clear_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_if.sv
// line_clear_ctrl_if: signal bundle between the line-clear controller and the game side
// (game logic plus the playfield map memory).
//   slave  : the controller itself
//   master : game logic / map memory / testbench
// The map answers rd_row with rd_data combinationally in the same cycle.
interface line_clear_ctrl_if #(
   parameter int COLS = 10
);
   logic              start;
   logic              clear_score;
   logic              busy;
   logic              done;
   logic [4:0]        rd_row;
   logic [COLS*5-1:0] rd_data;
   logic              wr_en;
   logic [4:0]        wr_row;
   logic [COLS*5-1:0] wr_data;
   logic [4:0]        lines_cleared;
   logic [15:0]       score;
   logic [15:0]       best_score;

   modport master (
      output start, clear_score, rd_data,
      input  busy, done, rd_row, wr_en, wr_row, wr_data,
      input  lines_cleared, score, best_score
   );

   modport slave (
      input  start, clear_score, rd_data,
      output busy, done, rd_row, wr_en, wr_row, wr_data,
      output lines_cleared, score, best_score
   );
endinterface

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: after a piece locks, walks the playfield bottom-up one row per cycle,
// drops every full row, copies the surviving rows down to close the gaps, then zero-fills
// the rows left vacant at the top. Reports the number of rows removed and keeps a
// saturating 16-bit score plus the best score seen since reset.
// Optional feature macro: LINE_BONUS_EN -- when defined a pass clearing k rows scores k*k,
// otherwise it scores k.
module line_clear_ctrl #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input logic              CLOCK_50,
   input logic              reset,
   line_clear_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [1:0]        r_state;
   logic [4:0]        r_rd_ptr;
   logic [4:0]        r_wr_ptr;
   logic [5:0]        r_cleared;     // up to 32 rows in one pass
   logic [4:0]        r_lines;
   logic [15:0]       r_score;
   logic [15:0]       r_best;

   logic              w_row_full;
   logic [5:0]        w_cleared_next;
   logic [10:0]       w_inc;
   logic [16:0]       w_sum;
   logic [15:0]       w_sat;
   logic [15:0]       w_score_next;
   logic [15:0]       w_best_next;
   logic [4:0]        w_rd_row;
   logic              w_wr_en;
   logic [4:0]        w_wr_row;
   logic [COLS*5-1:0] w_wr_data;

   // A row is full only when every cell holds a locked code (1..9); active-piece and
   // unused codes count as holes.
   function automatic logic row_full(input logic [COLS*5-1:0] row);
      logic f;
      f = 1'b1;
      for (int j = 0; j < COLS; j++) begin
         if ((row[j*5 +: 5] == 5'd0) || (row[j*5 +: 5] > 5'd9)) begin
            f = 1'b0;
         end else begin
            f = f;
         end
      end
      return f;
   endfunction

   // Classify the row currently being scanned and form the running clear count
   always_comb begin
      w_row_full     = 1'b0;
      w_cleared_next = r_cleared;
      if (r_state == S_SCAN) begin
         w_row_full = row_full(bus.rd_data);
      end else begin
         w_row_full = 1'b0;
      end
      if (w_row_full) begin
         w_cleared_next = r_cleared + 6'd1;
      end else begin
         w_cleared_next = r_cleared;
      end
   end

   // Score next-state: full-width add, saturate at 65535; clear_score overrides the DONE update
   always_comb begin
`ifdef LINE_BONUS_EN
      w_inc = 11'(r_cleared) * 11'(r_cleared);
`else
      w_inc = 11'(r_cleared);
`endif
      w_sum        = {1'b0, r_score} + {6'd0, w_inc};
      w_sat        = 16'd0;
      w_score_next = r_score;
      w_best_next  = r_best;
      if (w_sum[16]) begin
         w_sat = 16'hFFFF;
      end else begin
         w_sat = w_sum[15:0];
      end
      if (bus.clear_score) begin
         w_score_next = 16'd0;
         w_best_next  = r_best;
      end else if (r_state == S_DONE) begin
         w_score_next = w_sat;
         if (w_sat > r_best) begin
            w_best_next = w_sat;
         end else begin
            w_best_next = r_best;
         end
      end else begin
         w_score_next = r_score;
         w_best_next  = r_best;
      end
   end

   // Map port decode: read during SCAN, copy-down during SCAN, zero-fill during FILL;
   // writes are suppressed in any cycle where reset is high so an aborted pass stops at once
   always_comb begin
      w_rd_row  = 5'd0;
      w_wr_en   = 1'b0;
      w_wr_row  = 5'd0;
      w_wr_data = '0;
      case (r_state)
         S_SCAN: begin
            w_rd_row  = r_rd_ptr;
            w_wr_row  = r_wr_ptr;
            w_wr_data = bus.rd_data;
            if (!w_row_full && (r_wr_ptr != r_rd_ptr)) begin
               w_wr_en = 1'b1;
            end else begin
               w_wr_en = 1'b0;
            end
         end
         S_FILL: begin
            w_wr_en   = 1'b1;
            w_wr_row  = r_wr_ptr;
            w_wr_data = '0;
         end
         default: begin
            w_rd_row  = 5'd0;
            w_wr_en   = 1'b0;
            w_wr_row  = 5'd0;
            w_wr_data = '0;
         end
      endcase
      if (reset) begin
         w_wr_en = 1'b0;
      end else begin
         w_wr_en = w_wr_en;
      end
   end

   // Pass sequencing: IDLE -> SCAN -> (FILL when rows were removed) -> DONE -> IDLE
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_rd_ptr  <= 5'd0;
         r_wr_ptr  <= 5'd0;
         r_cleared <= 6'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state   <= S_SCAN;
                  r_rd_ptr  <= LAST_ROW;
                  r_wr_ptr  <= LAST_ROW;
                  r_cleared <= 6'd0;
               end
            end
            S_SCAN: begin
               r_rd_ptr  <= r_rd_ptr - 5'd1;
               r_cleared <= w_cleared_next;
               if (!w_row_full) begin
                  r_wr_ptr <= r_wr_ptr - 5'd1;
               end
               if (r_rd_ptr == 5'd0) begin
                  if (w_cleared_next != 6'd0) begin
                     r_state <= S_FILL;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_FILL: begin
               r_wr_ptr <= r_wr_ptr - 5'd1;
               if (r_wr_ptr == 5'd0) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Result registers: lines_cleared loads at DONE, score/best_score follow their next-state logic
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_lines <= 5'd0;
         r_score <= 16'd0;
         r_best  <= 16'd0;
      end else begin
         if (r_state == S_DONE) begin
            r_lines <= r_cleared[4:0];
         end
         r_score <= w_score_next;
         r_best  <= w_best_next;
      end
   end

   assign bus.busy          = (r_state == S_SCAN) || (r_state == S_FILL);
   assign bus.done          = (r_state == S_DONE);
   assign bus.rd_row        = w_rd_row;
   assign bus.wr_en         = w_wr_en;
   assign bus.wr_row        = w_wr_row;
   assign bus.wr_data       = w_wr_data;
   assign bus.lines_cleared = r_lines;
   assign bus.score         = r_score;
   assign bus.best_score    = r_best;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: randomized bench for line_clear_ctrl. The playfield map memory lives
// here; expected results come from a row-compaction model (keep the non-full rows in
// bottom-up order, zero the vacated rows at the top) plus plain score arithmetic.
`timescale 1ns/1ps
module tb_line_clear_ctrl;
   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int RW   = COLS * 5;
   typedef logic [RW-1:0] row_t;

   logic clk;
   logic rst;

   line_clear_ctrl_if #(.COLS(COLS)) bus ();

   line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bus)
   );

   row_t map      [ROWS];
   row_t load_map [ROWS];
   row_t e_map    [ROWS];
   logic load_en;
   int   wr_total;
   int   checks;
   int   errors;
   int   m_score;
   int   m_best;
   int   e_k;
   int   e_writes;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // map memory: combinational read, write on the clock edge
   assign bus.rd_data = (int'(bus.rd_row) < ROWS) ? map[bus.rd_row] : '0;

   // map write port and bulk loader
   always @(posedge clk) begin
      if (load_en === 1'b1) begin
         for (int i = 0; i < ROWS; i++) map[i] <= load_map[i];
      end else if (bus.wr_en === 1'b1) begin
         if (int'(bus.wr_row) < ROWS) map[bus.wr_row] <= bus.wr_data;
         wr_total <= wr_total + 1;
      end
   end

   function automatic bit is_locked(logic [4:0] c);
      return (c >= 5'd1) && (c <= 5'd9);
   endfunction

   function automatic bit is_full(row_t x);
      for (int j = 0; j < COLS; j++) begin
         if (!is_locked(x[j*5 +: 5])) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int points(int k);
`ifdef LINE_BONUS_EN
      return k * k;
`else
      return k;
`endif
   endfunction

   function automatic row_t full_row();
      row_t x;
      x = '0;
      for (int j = 0; j < COLS; j++) x[j*5 +: 5] = 5'($urandom_range(1, 9));
      return x;
   endfunction

   function automatic row_t partial_row();
      row_t x;
      int   kind;
      int   pos;
      x    = '0;
      kind = $urandom_range(0, 2);
      for (int j = 0; j < COLS; j++) begin
         case (kind)
            0:       x[j*5 +: 5] = 5'($urandom_range(0, 31));
            1:       x[j*5 +: 5] = 5'($urandom_range(1, 9));
            default: x[j*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 19)) : 5'd0;
         endcase
      end
      pos = $urandom_range(0, COLS - 1);
      x[pos*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(10, 31));
      return x;
   endfunction

   function automatic row_t random_row();
      if ($urandom_range(0, 2) == 0) return full_row();
      return partial_row();
   endfunction

   task automatic do_load();
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // reference: compact the loaded map, count removed rows and row writes, update score
   task automatic model_pass();
      row_t keep[$];
      bit   seen_full;
      e_k       = 0;
      e_writes  = 0;
      seen_full = 1'b0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (is_full(load_map[i])) begin
            e_k++;
            seen_full = 1'b1;
         end else begin
            keep.push_back(load_map[i]);
            if (seen_full) e_writes++;
         end
      end
      e_writes += e_k;
      for (int i = 0; i < ROWS; i++) e_map[i] = '0;
      foreach (keep[n]) e_map[ROWS - 1 - n] = keep[n];
      m_score = m_score + points(e_k);
      if (m_score > 65535) m_score = 65535;
      if (m_score > m_best) m_best = m_score;
   endtask

   // one pass: pulse start, follow it cycle by cycle; extra_start>0 re-pulses start at that
   // cycle, extra_start==0 re-pulses it in the done cycle
   task automatic run_pass(input int extra_start, input bit clr_at_done,
                           output int lat, output int nbusy);
      int n;
      lat   = -1;
      nbusy = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (n <= 200 && lat < 0) begin
         if (bus.busy === 1'b1) nbusy++;
         checks++;
         if (n <= ROWS) begin
            if (bus.rd_row !== 5'(ROWS - n)) begin
               errors++;
               $display("FAIL rd_row cycle %0d got %0d expected %0d", n, bus.rd_row, ROWS - n);
            end
         end else begin
            if (bus.rd_row !== 5'd0) begin
               errors++;
               $display("FAIL rd_row_idle cycle %0d got %0d expected 0", n, bus.rd_row);
            end
         end
         if (bus.busy !== 1'b1) begin
            checks++;
            if (bus.wr_en !== 1'b0) begin
               errors++;
               $display("FAIL wr_en_not_busy cycle %0d got %b expected 0", n, bus.wr_en);
            end
         end
         if (n == extra_start) bus.start = 1'b1;
         else                  bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            lat = n;
            if (extra_start == 0) bus.start = 1'b1;
            if (clr_at_done) bus.clear_score = 1'b1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got none expected done within 200 cycles");
      end
      @(negedge clk);
      bus.start       = 1'b0;
      bus.clear_score = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse got done=%b busy=%b expected 0 0", bus.done, bus.busy);
      end
   endtask

   // load_map must already hold the starting map
   task automatic pass_and_verify(input string tag, input int extra_start, input bit clr_at_done);
      int lat;
      int nbusy;
      int w0;
      int bad;
      do_load();
      model_pass();
      if (clr_at_done) m_score = 0;
      w0 = wr_total;
      run_pass(extra_start, clr_at_done, lat, nbusy);
      checks++;
      if (lat != ROWS + 1 + e_k) begin
         errors++;
         $display("FAIL latency_%s got %0d expected %0d", tag, lat, ROWS + 1 + e_k);
      end
      checks++;
      if (nbusy != ROWS + e_k) begin
         errors++;
         $display("FAIL busy_cycles_%s got %0d expected %0d", tag, nbusy, ROWS + e_k);
      end
      checks++;
      if (wr_total - w0 != e_writes) begin
         errors++;
         $display("FAIL writes_%s got %0d expected %0d", tag, wr_total - w0, e_writes);
      end
      bad = 0;
      for (int i = 0; i < ROWS; i++) if (map[i] !== e_map[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL map_%s rows_differing %0d expected 0", tag, bad);
      end
      checks++;
      if (bus.lines_cleared !== 5'(e_k)) begin
         errors++;
         $display("FAIL lines_%s got %0d expected %0d", tag, bus.lines_cleared, e_k);
      end
      checks++;
      if (bus.score !== 16'(m_score)) begin
         errors++;
         $display("FAIL score_%s got %0d expected %0d", tag, bus.score, m_score);
      end
      checks++;
      if (bus.best_score !== 16'(m_best)) begin
         errors++;
         $display("FAIL best_%s got %0d expected %0d", tag, bus.best_score, m_best);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_wr_en got %b expected 0", bus.wr_en);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_row !== 5'd0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b done=%b rd_row=%0d expected 0 0 0",
                  bus.busy, bus.done, bus.rd_row);
      end
      checks++;
      if (bus.lines_cleared !== 5'd0 || bus.score !== 16'd0 || bus.best_score !== 16'd0) begin
         errors++;
         $display("FAIL reset_results got lines=%0d score=%0d best=%0d expected 0 0 0",
                  bus.lines_cleared, bus.score, bus.best_score);
      end
   endtask

   task automatic test_empty();
      for (int i = 0; i < ROWS; i++) load_map[i] = '0;
      pass_and_verify("empty", -1, 1'b0);
   endtask

   task automatic test_single_line();
      for (int i = 0; i < ROWS; i++) load_map[i] = '0;
      for (int j = 0; j < COLS; j++) load_map[ROWS-1][j*5 +: 5] = 5'd3;
      load_map[ROWS-2] = RW'(5);
      pass_and_verify("single", -1, 1'b0);
      checks++;
      if (map[ROWS-1] !== RW'(5) || map[0] !== '0 || bus.score !== 16'd1) begin
         errors++;
         $display("FAIL single_explicit got row19=%0h row0=%0h score=%0d expected 5 0 1",
                  map[ROWS-1], map[0], bus.score);
      end
   endtask

   task automatic test_two_lines();
      int   s0;
      row_t r18;
      for (int i = 0; i < ROWS; i++) load_map[i] = partial_row();
      load_map[ROWS-1] = full_row();
      load_map[ROWS-3] = full_row();
      r18 = load_map[ROWS-2];
      s0  = m_score;
      pass_and_verify("two", -1, 1'b0);
      checks++;
      if (map[ROWS-1] !== r18 || map[1] !== '0 || map[0] !== '0) begin
         errors++;
         $display("FAIL two_rows got row19=%0h row1=%0h row0=%0h expected %0h 0 0",
                  map[ROWS-1], map[1], map[0], r18);
      end
      checks++;
`ifdef LINE_BONUS_EN
      if (int'(bus.score) != s0 + 4) begin
         errors++;
         $display("FAIL two_score got %0d expected %0d", bus.score, s0 + 4);
      end
`else
      if (int'(bus.score) != s0 + 2) begin
         errors++;
         $display("FAIL two_score got %0d expected %0d", bus.score, s0 + 2);
      end
`endif
   endtask

   task automatic test_active_piece();
      for (int i = 0; i < ROWS; i++) load_map[i] = '0;
      for (int j = 0; j < COLS; j++) load_map[ROWS-1][j*5 +: 5] = 5'd11;
      pass_and_verify("active", -1, 1'b0);
   endtask

   task automatic test_all_full();
      for (int i = 0; i < ROWS; i++) load_map[i] = full_row();
      pass_and_verify("all_full", -1, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < ROWS; i++) load_map[i] = random_row();
         pass_and_verify("random", -1, 1'b0);
      end
   endtask

   task automatic test_start_ignored();
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < ROWS; i++) load_map[i] = random_row();
         if (t < 6) pass_and_verify("restart_mid", $urandom_range(2, ROWS + 1), 1'b0);
         else       pass_and_verify("restart_done", 0, 1'b0);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] preset_v;
      for (int i = 0; i < ROWS; i++) load_map[i] = partial_row();
      for (int i = ROWS - 4; i < ROWS; i++) load_map[i] = full_row();
      // preload the score near the ceiling so the run stays short
      preset_v = 16'(65534 - points(4));
      @(negedge clk);
      force dut.r_score = preset_v;
      @(negedge clk);
      release dut.r_score;
      m_score = int'(preset_v);
      pass_and_verify("sat_a", -1, 1'b0);
      checks++;
      if (bus.score !== 16'd65534) begin
         errors++;
         $display("FAIL sat_65534 got %0d expected 65534", bus.score);
      end
      for (int i = 0; i < ROWS; i++) load_map[i] = partial_row();
      load_map[ROWS-1] = full_row();
      load_map[5]      = full_row();
      pass_and_verify("sat_b", -1, 1'b0);
      checks++;
      if (bus.score !== 16'd65535 || bus.best_score !== 16'd65535) begin
         errors++;
         $display("FAIL sat_ceiling got score=%0d best=%0d expected 65535 65535",
                  bus.score, bus.best_score);
      end
      @(negedge clk);
      bus.clear_score = 1'b1;
      @(negedge clk);
      bus.clear_score = 1'b0;
      m_score = 0;
      checks++;
      if (bus.score !== 16'd0 || bus.best_score !== 16'd65535) begin
         errors++;
         $display("FAIL clear_score got score=%0d best=%0d expected 0 65535",
                  bus.score, bus.best_score);
      end
   endtask

   task automatic test_clear_at_done();
      for (int i = 0; i < ROWS; i++) load_map[i] = partial_row();
      load_map[ROWS-2] = full_row();
      pass_and_verify("clr_done", -1, 1'b1);
      checks++;
      if (bus.score !== 16'd0 || bus.lines_cleared !== 5'd1) begin
         errors++;
         $display("FAIL clr_done_explicit got score=%0d lines=%0d expected 0 1",
                  bus.score, bus.lines_cleared);
      end
   endtask

   task automatic test_reset_midpass();
      int w0;
      int bad;
      for (int i = 0; i < ROWS; i++) load_map[i] = partial_row();
      load_map[ROWS-1] = full_row();
      do_load();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);          // cycle 1
      bus.start = 1'b0;
      @(negedge clk);          // cycle 2: a second start here must be ignored
      bus.start = 1'b1;
      @(negedge clk);          // cycle 3
      bus.start = 1'b0;
      @(negedge clk);          // cycle 4
      @(negedge clk);          // cycle 5
      rst = 1'b1;
      #1;
      checks++;
      if (bus.wr_en !== 1'b0) begin
         errors++;
         $display("FAIL midpass_wr_en got %b expected 0", bus.wr_en);
      end
      w0 = wr_total;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.score !== 16'd0 ||
          bus.best_score !== 16'd0 || bus.lines_cleared !== 5'd0) begin
         errors++;
         $display("FAIL midpass_reset got busy=%b done=%b score=%0d best=%0d lines=%0d expected all 0",
                  bus.busy, bus.done, bus.score, bus.best_score, bus.lines_cleared);
      end
      @(negedge clk);
      rst = 1'b0;
      m_score = 0;
      m_best  = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || wr_total != w0) begin
         errors++;
         $display("FAIL midpass_abort got busy=%b writes=%0d expected 0 0", bus.busy, wr_total - w0);
      end
      // rows written before the abort stay written; nothing else changes
      for (int i = 0; i < ROWS; i++) e_map[i] = load_map[i];
      e_map[ROWS-1] = load_map[ROWS-2];
      e_map[ROWS-2] = load_map[ROWS-3];
      e_map[ROWS-3] = load_map[ROWS-4];
      bad = 0;
      for (int i = 0; i < ROWS; i++) if (map[i] !== e_map[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midpass_map rows_differing %0d expected 0", bad);
      end
      for (int i = 0; i < ROWS; i++) load_map[i] = random_row();
      pass_and_verify("recover", -1, 1'b0);
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      m_score         = 0;
      m_best          = 0;
      load_en         = 1'b0;
      bus.start       = 1'b0;
      bus.clear_score = 1'b0;
      rst             = 1'b1;
      test_reset();
      test_empty();
      test_single_line();
      test_two_lines();
      test_active_piece();
      test_all_full();
      test_random();
      test_start_ignored();
      test_saturation();
      test_clear_at_done();
      test_reset_midpass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
